gig_eth_rx_frame_fifo: RTL
==========================

Name: gig_eth_rx_frame_fifo

Overview:
Frame-commit buffer placed between the gigabit MAC RX client interface and the downstream packet datapath. All logic runs on rx_clk.
Bytes are written speculatively into an internal RAM. A frame is made visible to the reader only when mac_rx_goodframe arrives. A frame is rolled back on mac_rx_badframe, or when the buffer overflows mid-frame.
The block also keeps good, bad and dropped frame statistics.

Parameters:
ADDR_WIDTH, 12, log2 of buffer depth in words (default 4096 entries of 9 bits: {eop, data[7:0]})
CNT_WIDTH, 16, width of statistics counters

Ports:
rx_clk  in  1  clock for write and read sides
reset  in  1  asynchronous, active-high reset
mac_rx_data  in  8  frame byte from MAC
mac_rx_dvld  in  1  byte valid, high for the whole frame body
mac_rx_goodframe  in  1  1-cycle pulse: last frame good
mac_rx_badframe  in  1  1-cycle pulse: last frame bad
out_data  out  8  frame byte to the downstream consumer
out_eop  out  1  marks the last byte of the frame
out_valid  out  1  out_data/out_eop hold a committed word
out_ready  in  1  consumer accepts the word
stat_good_frames  out  CNT_WIDTH  number of committed frames
stat_bad_frames  out  CNT_WIDTH  number of frames rolled back on badframe
stat_drop_frames  out  CNT_WIDTH  number of frames rolled back on overflow
buf_full  out  1  write-side full, registered

Behaviour:
- Reset (async, active-high) values: all pointers = 0; state = IDLE; out_valid = 0; out_data = 0; out_eop = 0; all stat counters = 0; buf_full = 0. Any partial frame is discarded.
- Pointers are ADDR_WIDTH+1 bits: wr_ptr (speculative), commit_ptr, rd_ptr.
  - used = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
  - full when used == 2^ADDR_WIDTH. buf_full is the registered value of full.
- Hold register: each byte is held one cycle so that eop can be attached to the last byte.
- Write-side FSM states: IDLE, FRAME, WAIT_STATUS, DROP.
  - IDLE:
    - mac_rx_dvld=1: capture mac_rx_data into hold, go to FRAME.
    - goodframe/badframe pulses in IDLE (empty frame) are ignored and no counter changes.
  - FRAME, mac_rx_dvld=1:
    - Not full: write {0, hold} at wr_ptr, wr_ptr++, then hold = mac_rx_data.
    - Full: go to DROP with no write.
  - FRAME, mac_rx_dvld=0:
    - Not full: write {1, hold}, wr_ptr++, go to WAIT_STATUS.
    - Full: go to DROP.
  - WAIT_STATUS:
    - goodframe: commit_ptr = wr_ptr, stat_good++, go to IDLE.
    - badframe: wr_ptr = commit_ptr, stat_bad++, go to IDLE.
    - If both pulses arrive in the same cycle, badframe wins.
    - mac_rx_dvld is ignored in this state.
  - DROP:
    - Ignore data until goodframe or badframe, then wr_ptr = commit_ptr, stat_drop++ (stat_bad is not incremented), go to IDLE.
- Counters wrap modulo 2^CNT_WIDTH.
- Read side is first-word-fall-through with a registered output stage. The stage loads from RAM[rd_ptr] and increments rd_ptr when both hold:
  - rd_ptr != commit_ptr;
  - the output stage is empty, or (out_valid && out_ready).
- Read timing and handshake rules:
  - RAM read is synchronous.
  - out_valid asserts no later than 2 cycles after the commit_ptr update.
  - Sustained throughput is 1 word/cycle while out_ready=1.
  - out_data/out_eop stay stable while out_valid && !out_ready.
- Simultaneous write and read in one cycle are both allowed. full is evaluated on the pre-update pointers, so space freed by a same-cycle read is usable from the next cycle.
- Uncommitted words are never visible to the reader; rollback never disturbs committed data.
- A frame longer than 2^ADDR_WIDTH bytes always ends in DROP.

Test Plan:
- 64-byte frame 0x00..0x3F, then goodframe; out_ready=1 -> 64 output words; out_eop only on 0x3F; stat_good_frames=1; out_valid first high ≤ 2 cycles after goodframe.
- 64-byte frame then badframe, followed by a 60-byte good frame -> only the 60 bytes appear at the output; stat_bad_frames=1, stat_good_frames=1.
- ADDR_WIDTH=6, out_ready=0, 40-byte good frame then 40-byte frame -> second frame goes to DROP and is dropped; stat_drop_frames=1; after out_ready=1 exactly 40 bytes are output.
- Three back-to-back 10-byte good frames with out_ready toggling 1/0 every cycle -> 30 bytes in order, eop on bytes 10/20/30, no data changes while stalled.
- Async reset asserted mid-frame after 20 bytes, then a 16-byte good frame -> all outputs and counters are 0 during reset; only the 16-byte frame is output; stat_good_frames=1.
- goodframe pulse with no preceding mac_rx_dvld -> no output, all counters remain 0.

Source files
------------

// File: rtl/gig_eth_rx_frame_fifo_if.sv
// MAC RX client, downstream stream and statistics bundle for the frame-commit buffer.
interface gig_eth_rx_frame_fifo_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic [7:0]           mac_rx_data;
    logic                 mac_rx_dvld;
    logic                 mac_rx_goodframe;
    logic                 mac_rx_badframe;
    logic [7:0]           out_data;
    logic                 out_eop;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_WIDTH-1:0] stat_good_frames;
    logic [CNT_WIDTH-1:0] stat_bad_frames;
    logic [CNT_WIDTH-1:0] stat_drop_frames;
    logic                 buf_full;

    // Buffer side
    modport slave (
        input  mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe, out_ready,
        output out_data, out_eop, out_valid,
        output stat_good_frames, stat_bad_frames, stat_drop_frames, buf_full
    );

    // MAC + consumer side
    modport master (
        output mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe, out_ready,
        input  out_data, out_eop, out_valid,
        input  stat_good_frames, stat_bad_frames, stat_drop_frames, buf_full
    );
endinterface

// File: rtl/gig_eth_rx_frame_fifo.sv
// Gigabit MAC RX frame-commit buffer: speculative write, commit on goodframe,
// rollback on badframe or overflow, FWFT registered read stage.
module gig_eth_rx_frame_fifo #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    rx_clk,
    input  logic                    reset,
    gig_eth_rx_frame_fifo_if.slave  bus
);
    localparam int unsigned PTR_W  = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned WORD_W = 9;

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_WAIT_STATUS, S_DROP} state_t;

    state_t               r_state, w_state_nxt;
    logic [WORD_W-1:0]    r_ram [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [PTR_W-1:0]     w_wr_ptr_nxt, w_commit_ptr_nxt, w_used;
    logic [7:0]           r_hold;
    logic                 w_hold_ld, w_wr_en, w_wr_eop, w_full, w_rd_fire;
    logic                 w_inc_good, w_inc_bad, w_inc_drop;
    logic [7:0]           r_out_data;
    logic                 r_out_eop, r_out_valid;
    logic [CNT_WIDTH-1:0] r_stat_good, r_stat_bad, r_stat_drop;
    logic                 r_buf_full;

    assign w_used    = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_used == PTR_W'(DEPTH));
    assign w_rd_fire = (r_rd_ptr != r_commit_ptr) && (!r_out_valid || bus.out_ready);

    // Write-side state register, pointers, hold byte and statistics
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_hold       <= '0;
            r_stat_good  <= '0;
            r_stat_bad   <= '0;
            r_stat_drop  <= '0;
            r_buf_full   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
            r_buf_full   <= w_full;
            if (w_hold_ld)  r_hold      <= bus.mac_rx_data;
            if (w_inc_good) r_stat_good <= r_stat_good + CNT_WIDTH'(1);
            if (w_inc_bad)  r_stat_bad  <= r_stat_bad + CNT_WIDTH'(1);
            if (w_inc_drop) r_stat_drop <= r_stat_drop + CNT_WIDTH'(1);
        end
    end

    // Write-side next state; a status pulse coinciding with the end of dvld is honoured at once
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_hold_ld        = 1'b0;
        w_wr_en          = 1'b0;
        w_wr_eop         = 1'b0;
        w_inc_good       = 1'b0;
        w_inc_bad        = 1'b0;
        w_inc_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mac_rx_dvld) begin
                    w_hold_ld   = 1'b1;
                    w_state_nxt = S_FRAME;
                end
            end
            S_FRAME: begin
                if (bus.mac_rx_dvld) begin
                    if (w_full) begin
                        w_state_nxt = S_DROP;
                    end else begin
                        w_wr_en      = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                        w_hold_ld    = 1'b1;
                    end
                end else if (w_full) begin
                    if (bus.mac_rx_goodframe || bus.mac_rx_badframe) begin
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_inc_drop   = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_state_nxt = S_DROP;
                    end
                end else begin
                    w_wr_en      = 1'b1;
                    w_wr_eop     = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                    w_state_nxt  = S_WAIT_STATUS;
                    if (bus.mac_rx_badframe) begin
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_inc_bad    = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else if (bus.mac_rx_goodframe) begin
                        w_commit_ptr_nxt = r_wr_ptr + PTR_W'(1);
                        w_inc_good       = 1'b1;
                        w_state_nxt      = S_IDLE;
                    end
                end
            end
            S_WAIT_STATUS: begin
                if (bus.mac_rx_badframe) begin
                    w_wr_ptr_nxt = r_commit_ptr;
                    w_inc_bad    = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (bus.mac_rx_goodframe) begin
                    w_commit_ptr_nxt = r_wr_ptr;
                    w_inc_good       = 1'b1;
                    w_state_nxt      = S_IDLE;
                end
            end
            S_DROP: begin
                if (bus.mac_rx_goodframe || bus.mac_rx_badframe) begin
                    w_wr_ptr_nxt = r_commit_ptr;
                    w_inc_drop   = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame RAM write port
    always_ff @(posedge rx_clk) begin
        if (w_wr_en) r_ram[r_wr_ptr[ADDR_WIDTH-1:0]] <= {w_wr_eop, r_hold};
    end

    // Read pointer and registered output stage fed by the synchronous RAM read
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr    <= '0;
            r_out_data  <= '0;
            r_out_eop   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_rd_fire) begin
            {r_out_eop, r_out_data} <= r_ram[r_rd_ptr[ADDR_WIDTH-1:0]];
            r_out_valid             <= 1'b1;
            r_rd_ptr                <= r_rd_ptr + PTR_W'(1);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_data         = r_out_data;
    assign bus.out_eop          = r_out_eop;
    assign bus.out_valid        = r_out_valid;
    assign bus.stat_good_frames = r_stat_good;
    assign bus.stat_bad_frames  = r_stat_bad;
    assign bus.stat_drop_frames = r_stat_drop;
    assign bus.buf_full         = r_buf_full;
endmodule
